// File: rtl/cordic_ci_ctrl_if.sv
// Nios II multi-cycle custom-instruction bus between the CPU and the cosine front end.
interface cordic_ci_ctrl_if;
    logic        clk_en;
    logic        start;
    logic [1:0]  n;
    logic [31:0] dataa;
    logic        done;
    logic [31:0] result;

    modport master (output clk_en, start, n, dataa, input done, result);
    modport slave  (input clk_en, start, n, dataa, output done, result);
endinterface

// File: rtl/cordic_ci_ctrl.sv
// Custom-instruction front end for the combinational cosine iterator.
// Optional macro CORDIC_CI_ZERO_SHORTCUT_EN: +/-0 angles return 1.0 without waiting.
module cordic_ci_ctrl #(
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    cordic_ci_ctrl_if.slave  ci,
    output logic [31:0]      core_angle,
    input  logic [31:0]      core_result
);
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    localparam logic [1:0]  OP_COS   = 2'd0;
    localparam logic [1:0]  OP_LAST  = 2'd1;
    localparam logic [1:0]  OP_COUNT = 2'd2;
    localparam logic [1:0]  OP_CLEAR = 2'd3;
    localparam logic [3:0]  WAIT_INIT = 4'(SETTLE_CYCLES - 1);
    localparam logic [31:0] FP_ONE    = 32'h3F80_0000;

    state_t             state_q, state_d;
    logic [3:0]         wait_q, wait_d;
    logic [31:0]        result_q, result_d;
    logic [31:0]        last_q, last_d;
    logic [31:0]        angle_q, angle_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done_q, done_d;
    logic [31:0]        cnt_word;
    logic               zero_angle;

    generate
        if (CNT_W >= 32) begin : g_cnt_trunc
            assign cnt_word = cnt_q[31:0];
        end else begin : g_cnt_ext
            assign cnt_word = {{(32-CNT_W){1'b0}}, cnt_q};
        end
    endgenerate

`ifdef CORDIC_CI_ZERO_SHORTCUT_EN
    assign zero_angle = (ci.dataa[30:0] == 31'd0);
`else
    assign zero_angle = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        result_d = result_q;
        last_d   = last_q;
        angle_d  = angle_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (ci.start) begin
                    done_d  = 1'b1;
                    state_d = DONE;
                    case (ci.n)
                        OP_COS: begin
                            angle_d = ci.dataa;
                            if (zero_angle) begin
                                result_d = FP_ONE;
                                last_d   = FP_ONE;
                                cnt_d    = cnt_q + CNT_W'(1);
                            end else begin
                                // Iterator needs the settle window before its output is usable.
                                done_d  = 1'b0;
                                wait_d  = WAIT_INIT;
                                state_d = WAIT;
                            end
                        end
                        OP_LAST:  result_d = last_q;
                        OP_COUNT: result_d = cnt_word;
                        OP_CLEAR: begin
                            result_d = 32'd0;
                            last_d   = 32'd0;
                            cnt_d    = '0;
                        end
                        default: ;
                    endcase
                end
            end
            WAIT: begin
                if (wait_q != 4'd0) begin
                    wait_d = wait_q - 4'd1;
                end else begin
                    result_d = core_result;
                    last_d   = core_result;
                    cnt_d    = cnt_q + CNT_W'(1);
                    done_d   = 1'b1;
                    state_d  = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // clk_en low freezes everything, including the done pulse.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            wait_q   <= 4'd0;
            result_q <= 32'd0;
            last_q   <= 32'd0;
            angle_q  <= 32'd0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
        end else if (ci.clk_en) begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            result_q <= result_d;
            last_q   <= last_d;
            angle_q  <= angle_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
        end
    end

    assign ci.done    = done_q;
    assign ci.result  = result_q;
    assign core_angle = angle_q;
endmodule
